pci_arbiter: RTL

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI bus arbiter with grant timeout and registered inputs.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
module pci_arbiter #(
  parameter int NUM_DEV     = 4,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DEV-1:0] request,
  input  logic               iframe,
  input  logic               iready,
  output logic [NUM_DEV-1:0] grant,
  output logic [2:0]         owner,
  output logic               bus_busy,
  output logic [1:0]         state_dbg
);

  // Handshake: request/grant/iframe/iready are all active-low; a device owns the bus
  // from the cycle its grant bit is low, starts a transaction by pulling iframe low,
  // and the bus is idle again on the first sampled cycle with iframe and iready high.
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, TURN} state_t;

  state_t             state_q, state_d;
  logic [NUM_DEV-1:0] grant_q, grant_d;
  logic [2:0]         owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               skip_vld_q, skip_vld_d;
  logic [2:0]         skip_idx_q, skip_idx_d;
  logic [NUM_DEV-1:0] req_q;
  logic               frame_q, irdy_q;

  logic [NUM_DEV-1:0] cand;
  logic               found;
  logic [2:0]         winner;
  logic               own_req_n;

  function automatic logic [NUM_DEV-1:0] gnt_of(input logic [2:0] idx);
    logic [NUM_DEV-1:0] g;
    g = '1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx == 3'(i)) g[i] = 1'b0;
    end
    return g;
  endfunction

  // Round-robin search starting at owner+1; the owner itself is examined last.
  always_comb begin
    cand = ~req_q;
    own_req_n = 1'b1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (skip_vld_q && (skip_idx_q == 3'(i))) cand[i] = 1'b0;
      if (owner_q == 3'(i)) own_req_n = req_q[i];
    end
    found  = 1'b0;
    winner = owner_q;
    for (int k = NUM_DEV; k >= 1; k--) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        if ((i == ((int'(owner_q) + k) % NUM_DEV)) && cand[i]) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    skip_vld_d = skip_vld_q;
    skip_idx_d = skip_idx_q;
    case (state_q)
      IDLE: begin
        // A timed-out device sits out exactly one search round.
        if (|(~req_q)) skip_vld_d = 1'b0;
`ifdef PCI_ARB_PARK_EN
        if (found) begin
          if ((grant_q != '1) && (winner != owner_q)) begin
            grant_d = '1;
          end else begin
            grant_d = gnt_of(winner);
            owner_d = winner;
            cnt_d   = 8'd0;
            state_d = GRANTED;
          end
        end else begin
          grant_d = gnt_of(owner_q);
        end
`else
        if (found) begin
          grant_d = gnt_of(winner);
          owner_d = winner;
          cnt_d   = 8'd0;
          state_d = GRANTED;
        end else begin
          grant_d = '1;
        end
`endif
      end
      GRANTED: begin
        cnt_d = cnt_q + 8'd1;
        if (!frame_q) begin
          state_d = BUSY;
        end else if (own_req_n) begin
          grant_d = '1;
          state_d = IDLE;
        end else if (cnt_q == 8'(GNT_TIMEOUT - 1)) begin
          grant_d    = '1;
          state_d    = IDLE;
          skip_vld_d = 1'b1;
          skip_idx_d = owner_q;
        end
      end
      BUSY: begin
        if (frame_q && irdy_q) begin
          grant_d = '1;
          state_d = TURN;
        end
      end
      TURN: begin
        grant_d = '1;
        state_d = IDLE;
      end
      default: begin
        grant_d = '1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '1;
      owner_q    <= 3'(NUM_DEV - 1);
      busy_q     <= 1'b0;
      cnt_q      <= 8'd0;
      skip_vld_q <= 1'b0;
      skip_idx_q <= 3'd0;
      req_q      <= '1;
      frame_q    <= 1'b1;
      irdy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      skip_vld_q <= skip_vld_d;
      skip_idx_q <= skip_idx_d;
      req_q      <= request;
      frame_q    <= iframe;
      irdy_q     <= iready;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign bus_busy  = busy_q;
  assign state_dbg = state_q;

endmodule
